// File: rtl/bep_frame_controller.sv
// Frames the biphase decoder's bit stream: sync-word hunt, fixed-width payload capture,
// valid/ready frame output, and decoder reset sequencing on disable and bit timeout.
module bep_frame_controller #(
  parameter int                    SYNC_WIDTH     = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD      = 8'hA5,
  parameter int                    PAYLOAD_WIDTH  = 16,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     bit_data,
  input  logic                     bit_strobe,
  output logic [PAYLOAD_WIDTH-1:0] frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     decoder_reset,
  output logic [1:0]               state,
  output logic                     sync_lock,
  output logic                     err_timeout,
  output logic                     err_overrun
);

  localparam int SHREG_WIDTH = (SYNC_WIDTH > PAYLOAD_WIDTH) ? SYNC_WIDTH : PAYLOAD_WIDTH;
  localparam int HUNT_CW     = $clog2(SYNC_WIDTH + 1);
  localparam int BIT_CW      = $clog2(PAYLOAD_WIDTH + 1);
  localparam int TO_CW       = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [HUNT_CW-1:0] HUNT_LAST = HUNT_CW'(SYNC_WIDTH - 1);
  localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(PAYLOAD_WIDTH - 1);
  // Decided one cycle early so the registered pulse lands TIMEOUT_CYCLES after the last accept.
  localparam logic [TO_CW-1:0]   TO_LAST   = TO_CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    RECEIVE = 2'd2
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic                   strobe_q_reg;
  logic [SHREG_WIDTH-2:0] shreg_reg;
  logic [HUNT_CW-1:0]     hunt_cnt_reg;
  logic [BIT_CW-1:0]      bit_cnt_reg;
  logic [TO_CW-1:0]       tcnt_reg;

  logic                   accept;
  logic [SHREG_WIDTH-1:0] window;
  logic [SYNC_WIDTH-1:0]  sync_eq;
  logic                   sync_hit;
  logic                   frame_done;
  logic                   timeout_hit;
  logic                   frame_load;

  assign accept = bit_strobe & ~strobe_q_reg;
  // shreg_reg keeps all but the newest bit; window is the full history including this cycle's bit
  assign window = {shreg_reg, bit_data};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_WIDTH; gi++) begin : g_sync_cmp
      assign sync_eq[gi] = ~(window[gi] ^ SYNC_WORD[gi]);
    end
  endgenerate

  assign sync_hit    = (state_reg == HUNT) && accept && (&sync_eq) && (hunt_cnt_reg == HUNT_LAST);
  assign frame_done  = enable && (state_reg == RECEIVE) && accept && (bit_cnt_reg == BIT_LAST);
  assign timeout_hit = enable && (state_reg == RECEIVE) && !accept && (tcnt_reg == TO_LAST);
  assign frame_load  = frame_done && (!frame_valid || frame_ready);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = HUNT;
      HUNT:    if (sync_hit) state_next = RECEIVE;
      RECEIVE: if (frame_done || timeout_hit) state_next = HUNT;
      default: state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      strobe_q_reg  <= 1'b0;
      shreg_reg     <= '0;
      hunt_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      tcnt_reg      <= '0;
      frame_data    <= '0;
      frame_valid   <= 1'b0;
      decoder_reset <= 1'b1;
      sync_lock     <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      strobe_q_reg  <= bit_strobe;
      state_reg     <= state_next;
      sync_lock     <= (state_next == RECEIVE);
      decoder_reset <= (state_next == IDLE) || timeout_hit;
      err_timeout   <= timeout_hit;
      err_overrun   <= frame_done && frame_valid && !frame_ready;

      if (state_next == HUNT && state_reg != HUNT) begin
        shreg_reg    <= '0;
        hunt_cnt_reg <= '0;
      end else if (state_reg == HUNT && accept) begin
        shreg_reg <= window[SHREG_WIDTH-2:0];
        if (hunt_cnt_reg != HUNT_LAST) hunt_cnt_reg <= hunt_cnt_reg + 1'b1;
      end else if (state_reg == RECEIVE && accept) begin
        shreg_reg <= window[SHREG_WIDTH-2:0];
      end

      if (state_next == RECEIVE && state_reg != RECEIVE) begin
        bit_cnt_reg <= '0;
        tcnt_reg    <= '0;
      end else if (state_reg == RECEIVE) begin
        if (accept) begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          tcnt_reg    <= '0;
        end else begin
          tcnt_reg <= tcnt_reg + 1'b1;
        end
      end

      // A frame loading in the same cycle as a handshake replaces the consumed one.
      if (frame_load) begin
        frame_data  <= window[PAYLOAD_WIDTH-1:0];
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

  assign state = state_reg;

endmodule
